// File: rtl/pkt_filter_ctrl.sv
// pkt_filter_ctrl: packet sequencer around filter_core. Captures the first beat
//   of each packet as the header, registers the filter verdict, then forwards
//   or silently consumes the packet.
// Latency: header out one VERDICT bubble after accept; body beats pass through
//   combinationally (zero cycles).
// Backpressure: s_tready low in VERDICT/HDR_OUT; in PASS s_tready follows
//   m_tready; DROP always accepts.
// Ports:
//   clk, rst              single clock, async active-high reset
//   s_tdata/tvalid/tlast/tready   slave beat port
//   hdr_data, filt_pass   captured header to filter_core, verdict back
//   m_tdata/tvalid/tlast/tready   master beat port
//   stat_clr, pass_cnt, drop_cnt  statistics (PKT_FILTER_STATS_EN)
// Build option: define PKT_FILTER_STATS_EN to implement the pass/drop
//   counters; otherwise they are tied to zero and stat_clr is ignored.

module pkt_filter_ctrl #(
  parameter int DATA_W = 512,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [DATA_W-1:0] hdr_data,
  input  logic              filt_pass,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    VERDICT = 3'd1,
    HDR_OUT = 3'd2,
    PASS    = 3'd3,
    DROP    = 3'd4
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] hdr_reg_q;
  logic              hdr_last_q;
  logic              verdict_q;

  // Packet sequencer. hdr_reg_q is only written in IDLE, so it is stable
  // through VERDICT while filter_core evaluates it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hdr_reg_q  <= '0;
      hdr_last_q <= 1'b0;
      verdict_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_tvalid) begin
            hdr_reg_q  <= s_tdata;
            hdr_last_q <= s_tlast;
            state_q    <= VERDICT;
          end
        end
        VERDICT: begin
          verdict_q <= filt_pass;
          if (filt_pass)       state_q <= HDR_OUT;
          else if (hdr_last_q) state_q <= IDLE;
          else                 state_q <= DROP;
        end
        HDR_OUT: begin
          if (m_tready) state_q <= hdr_last_q ? IDLE : PASS;
        end
        PASS: begin
          if (s_tvalid && m_tready && s_tlast) state_q <= IDLE;
        end
        DROP: begin
          if (s_tvalid && s_tlast) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hdr_data = hdr_reg_q;

  // Output decode. m_tvalid never looks at m_tready; s_tready only does so
  // in PASS. While reset is held IDLE does not advertise ready.
  always_comb begin
    s_tready = 1'b0;
    m_tvalid = 1'b0;
    m_tdata  = hdr_reg_q;
    m_tlast  = hdr_last_q;
    case (state_q)
      IDLE:    s_tready = ~rst;
      // HDR_OUT is only reachable on a pass, so the registered verdict is
      // high here; it qualifies the header beat.
      HDR_OUT: m_tvalid = verdict_q;
      PASS: begin
        m_tvalid = s_tvalid;
        m_tdata  = s_tdata;
        m_tlast  = s_tlast;
        s_tready = m_tready;
      end
      DROP:    s_tready = 1'b1;
      default: ;
    endcase
  end

`ifdef PKT_FILTER_STATS_EN
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating counters, bumped once per packet in its VERDICT cycle.
  // A clear wins over a same-cycle increment.
  always_comb begin
    pass_cnt_d = pass_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (stat_clr) begin
      pass_cnt_d = '0;
      drop_cnt_d = '0;
    end else if (state_q == VERDICT) begin
      if (filt_pass) begin
        if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_W'(1);
      end else begin
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign pass_cnt = '0;
  assign drop_cnt = '0;
`endif

endmodule
